// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, ACK levels,
// default device address and the bit counter width.
package i2c_pkg;
   localparam int STATE_W   = 4;
   localparam int BIT_CNT_W = 3;

   localparam logic       ACK          = 1'b0;
   localparam logic       NACK         = 1'b1;
   localparam logic [6:0] MPU9250_ADDR = 7'h68;

   typedef enum logic [STATE_W-1:0] {
      IDLE, ADDR, ACK_ADDR, REG, ACK_REG, WDATA, ACK_W, RDATA, RACK, WAIT
   } i2c_state_e;
endpackage

// File: rtl/i2c_target_if.sv
// Register-file side of the I2C target: pointer, write strobe and read data.
interface i2c_target_if;
   import i2c_pkg::*;

   logic [7:0]         reg_addr;
   logic [7:0]         reg_wdata;
   logic               reg_we;
   logic [7:0]         reg_rdata;
   logic               busy;
   logic [STATE_W-1:0] state_out;

   modport master (output reg_addr, reg_wdata, reg_we, busy, state_out, input reg_rdata);
   modport slave  (input reg_addr, reg_wdata, reg_we, busy, state_out, output reg_rdata);
endinterface

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus SCL edge and START/STOP pulses.
module i2c_bus_sync (
   input  logic clock,
   input  logic reset,
   input  logic scl,
   input  logic sda,
   output logic sda_lvl,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);
   logic [1:0] scl_ff, sda_ff;
   logic       scl_d, sda_d;
   logic       scl_lvl;

   // Idle bus is high, so reset to 1 to avoid a phantom edge after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         scl_ff <= 2'b11;
         sda_ff <= 2'b11;
         scl_d  <= 1'b1;
         sda_d  <= 1'b1;
      end else begin
         scl_ff <= {scl_ff[0], scl};
         sda_ff <= {sda_ff[0], sda};
         scl_d  <= scl_ff[1];
         sda_d  <= sda_ff[1];
      end
   end

   assign scl_lvl   = scl_ff[1];
   assign sda_lvl   = sda_ff[1];
   assign scl_rise  = scl_lvl & ~scl_d;
   assign scl_fall  = ~scl_lvl & scl_d;
   assign start_det = scl_lvl & scl_d & sda_d & ~sda_lvl;
   assign stop_det  = scl_lvl & scl_d & ~sda_d & sda_lvl;
endmodule

// File: rtl/i2c_target.sv
// I2C register-access target, oversampled in the system clock domain.
// Never stretches SCL; SDA is open-drain (driven low or released).
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEVICE_ADDRESS = MPU9250_ADDR
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          scl,
   inout  wire           sda,
   i2c_target_if.master  bus
);
   logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

   i2c_bus_sync u_sync (
      .clock     (clock),
      .reset     (reset),
      .scl       (scl),
      .sda       (sda),
      .sda_lvl   (sda_lvl),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   i2c_state_e           state, state_n;
   logic [BIT_CNT_W-1:0] cnt, cnt_n;
   logic [6:0]           sr, sr_n;
   logic                 rw, rw_n;
   logic                 sda_oe, oe_n;
   logic [7:0]           ptr_q, ptr_n, wdata_q, wdata_n;
   logic                 we_q, we_n, busy_q, busy_n, ack_seen, ack_seen_n;

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         sr       <= '0;
         rw       <= 1'b0;
         sda_oe   <= 1'b0;
         ptr_q    <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         busy_q   <= 1'b0;
         ack_seen <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         sr       <= sr_n;
         rw       <= rw_n;
         sda_oe   <= oe_n;
         ptr_q    <= ptr_n;
         wdata_q  <= wdata_n;
         we_q     <= we_n;
         busy_q   <= busy_n;
         ack_seen <= ack_seen_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      sr_n       = sr;
      rw_n       = rw;
      oe_n       = sda_oe;
      ptr_n      = we_q ? ptr_q + 8'd1 : ptr_q;
      wdata_n    = wdata_q;
      we_n       = 1'b0;
      busy_n     = busy_q;
      ack_seen_n = ack_seen;
      if (stop_det) begin
         state_n = IDLE;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else if (start_det) begin
         state_n = ADDR;
         cnt_n   = 3'd7;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else begin
         unique case (state)
            IDLE, WAIT: ;
            ADDR: if (scl_rise) begin
               sr_n = {sr[5:0], sda_lvl};
               if (cnt == 3'd0) begin
                  rw_n = sda_lvl;
                  if (sr == DEVICE_ADDRESS) begin
                     state_n = ACK_ADDR;
                     busy_n  = 1'b1;
                  end else begin
                     state_n = WAIT;
                  end
               end else begin
                  cnt_n = cnt - 3'd1;
               end
            end
            // ACK states: first SCL fall starts the ack drive, second one ends it.
            ACK_ADDR: if (scl_fall) begin
               if (!sda_oe) begin
                  oe_n = 1'b1;
               end else if (rw) begin
                  state_n = RDATA;
                  sr_n    = bus.reg_rdata[6:0];
                  oe_n    = ~bus.reg_rdata[7];
                  cnt_n   = 3'd7;
               end else begin
                  state_n = REG;
                  oe_n    = 1'b0;
                  cnt_n   = 3'd7;
               end
            end
            REG, WDATA: if (scl_rise) begin
               sr_n = {sr[5:0], sda_lvl};
               if (cnt == 3'd0) begin
                  if (state == REG) begin
                     ptr_n   = {sr, sda_lvl};
                     state_n = ACK_REG;
                  end else begin
                     wdata_n = {sr, sda_lvl};
                     we_n    = 1'b1;
                     state_n = ACK_W;
                  end
               end else begin
                  cnt_n = cnt - 3'd1;
               end
            end
            ACK_REG, ACK_W: if (scl_fall) begin
               if (!sda_oe) begin
                  oe_n = 1'b1;
               end else begin
                  state_n = WDATA;
                  oe_n    = 1'b0;
                  cnt_n   = 3'd7;
               end
            end
            RDATA: if (scl_fall) begin
               if (cnt == 3'd0) begin
                  oe_n       = 1'b0;
                  state_n    = RACK;
                  ack_seen_n = 1'b0;
               end else begin
                  cnt_n = cnt - 3'd1;
                  oe_n  = ~sr[6];
                  sr_n  = {sr[5:0], 1'b0};
               end
            end
            RACK: if (scl_rise) begin
               ptr_n = ptr_q + 8'd1;
               if (sda_lvl == ACK) begin
                  ack_seen_n = 1'b1;
               end else begin
                  state_n = WAIT;
                  busy_n  = 1'b0;
               end
            end else if (scl_fall && ack_seen) begin
               state_n = RDATA;
               sr_n    = bus.reg_rdata[6:0];
               oe_n    = ~bus.reg_rdata[7];
               cnt_n   = 3'd7;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign sda           = sda_oe ? 1'b0 : 1'bz;
   assign bus.reg_addr  = ptr_q;
   assign bus.reg_wdata = wdata_q;
   assign bus.reg_we    = we_q;
   assign bus.busy      = busy_q;
   assign bus.state_out = state;
endmodule

// File: doc/i2c_target.md
# i2c_target

Synchronous I2C target (slave) that answers the 7-bit-address register-read/write transactions issued by our I2C master. It exposes a byte-wide register-file port, so the FPGA can stand in for a sensor such as the MPU9250 at 0x68, either in loopback bring-up or as a peripheral seen by an external controller. It runs entirely in the system clock domain, oversampling SCL/SDA, and never stretches the clock.

## Interface
- DEVICE_ADDRESS, 7'h68, 7-bit address this target responds to
- clock  input  1  system clock, ≥ 16× SCL frequency
- reset  input  1  synchronous, active-high
- scl  input  1  bus clock, sampled only, never driven
- sda  inout  1  open-drain: driven 0 or released to 1'bz, external pull-up
- reg_addr  output  8  current register pointer
- reg_wdata  output  8  byte received for write
- reg_we  output  1  one-cycle write strobe, qualifies reg_addr/reg_wdata
- reg_rdata  input  8  register contents at reg_addr, valid 1 cycle after reg_addr changes
- busy  output  1  high from an address match until STOP, repeated START or error exit
- state_out  output  4  current FSM state, debug

## Operation
- Bus sampling: SCL and SDA pass through 2-FF synchronizers, then 1-cycle edge detect. START = SDA fall while SCL high; STOP = SDA rise while SCL high.
- Bits are sampled on SCL rise. Target-driven SDA changes only on SCL fall.
- FSM states: IDLE, ADDR, ACK_ADDR, REG, ACK_REG, WDATA, ACK_W, RDATA, RACK, WAIT.
- IDLE: on START, go to ADDR with bit count 7.
- ADDR: shift 8 bits, MSB first. After the 8th rise:
  - Address match → ACK_ADDR, drive SDA low from the next SCL fall for one bit.
  - Mismatch → WAIT, SDA stays released.
- ACK_ADDR end, at SCL fall:
  - R/W=0 → REG.
  - R/W=1 → latch reg_rdata into the shift register, go to RDATA, drive its MSB.
- REG: receive 8 bits into reg_addr, then ACK_REG (ack), then WDATA.
- WDATA: receive 8 bits, then ACK_W. During ACK_W:
  - Pulse reg_we once with reg_wdata = byte and reg_addr = pointer.
  - On the following cycle, increment reg_addr.
  - Return to WDATA.
- RDATA: drive 8 bits MSB first, then release SDA and go to RACK. At the RACK SCL rise, increment reg_addr.
  - SDA=0 (master ACK) → at SCL fall, latch reg_rdata and go to RDATA.
  - SDA=1 (master NACK) → WAIT.
- WAIT: SDA released; leave only on START (→ ADDR) or STOP (→ IDLE).
- START from any state → ADDR (repeated start). reg_addr is preserved, so the master's write-pointer-then-repeated-start-read sequence works.
- STOP from any state → IDLE, SDA released, partial bytes discarded, no reg_we.
- Pointer arithmetic: 8-bit, wraps 8'hFF → 8'h00 on both read and write increments.

## Timing
- Reset values: sda released (z), reg_addr=0, reg_wdata=0, reg_we=0, busy=0, state_out=IDLE.
- reset mid-transaction: SDA is released on the cycle after reset is sampled.
- Input latency: 2 cycles of synchronizer plus 1 cycle of edge detect.
- SDA drive/release: registered, takes effect ≤ 4 clocks after the physical SCL fall. The 16× ratio keeps this inside SCL low.
- reg_we: exactly one clock per received data byte, asserted during ACK_W.
- reg_rdata: sampled ≥ 2 clocks after reg_addr settles.
- busy: rises the clock after the address ACK decision; falls with the exit to IDLE/ADDR/WAIT.
- START and a bit-sample on the same cycle: START wins.

## Structure
- Package i2c_pkg holds:
  - the state enum and its 4-bit width
  - ACK=1'b0 and NACK=1'b1
  - the default MPU9250 address 7'h68
  - the shared master/target bit-count width
- One sub-module, i2c_bus_sync: 2-FF synchronizers for SCL/SDA plus scl_rise, scl_fall, start_det, stop_det pulses.

## Test plan
- Write: START, 0xD0, 0x6B, 0x00, STOP → three ACKs; one reg_we with addr 0x6B, data 0x00; reg_addr ends at 0x6C.
- Read: START 0xD0, 0x3B; repeated START 0xD1; rdata model 0x3B→0x12, 0x3C→0x34; master ACKs then NACKs → bytes 0x12, 0x34 on the bus (master reads 0x1234); reg_addr ends at 0x3D; no reg_we.
- Address miss: START 0xD2 → SDA never driven low, busy stays 0, FSM in WAIT until STOP.
- STOP mid-WDATA after 4 bits → IDLE, no reg_we, SDA released.
- Wrap: pointer 0xFF, write 0xAA, 0xBB → reg_we at 0xFF then 0x00; reg_addr ends at 0x01.
- reset asserted while RDATA is driving 0 → SDA z on the next cycle; state IDLE; reg_addr 0.
